inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 169 ++++++++++++++++
 tb/tb_inst_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Serial program loader. Receives a framed byte stream and writes the payload
// into instruction memory as 16-bit words, then releases the CPU from reset.
//
// Frame: HDR, N, {hi, lo} x N, checksum
//   checksum = XOR of every hi and lo byte (header and length excluded)
//
// Parameters
//   BASE_ADDR    byte address of the first instruction word written
//   HDR          frame header byte
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   in_data      incoming program byte
//   in_valid     in_data valid
//   in_ready     loader can accept a byte (low only once loading is done)
//   im_we        instruction-memory write strobe (one cycle per word)
//   im_addr      instruction-memory byte address
//   im_wdata     instruction word
//   cpu_run      high releases the CPU (frame loaded with good checksum)
//   err          sticky frame-error flag, cleared by the next header
//   words_loaded words written in the current frame
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [7:0]  HDR       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [15:0] im_wdata,
    output logic        cpu_run,
    output logic        err,
    output logic [7:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_n,     w_n_next;
    logic [7:0]  r_hi,    w_hi_next;
    logic [7:0]  r_csum,  w_csum_next;
    logic [7:0]  r_words, w_words_next;
    logic [15:0] r_ptr,   w_ptr_next;
    logic [15:0] r_addr,  w_addr_next;
    logic [15:0] r_wdata, w_wdata_next;
    logic        r_we,    w_we_next;
    logic        r_ready, w_ready_next;
    logic        r_run,   w_run_next;
    logic        r_err,   w_err_next;
    logic        w_accept;

    assign w_accept = in_valid & r_ready;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_n     <= 8'h00;
            r_hi    <= 8'h00;
            r_csum  <= 8'h00;
            r_words <= 8'h00;
            r_ptr   <= BASE_ADDR;
            r_addr  <= BASE_ADDR;
            r_wdata <= 16'h0000;
            r_we    <= 1'b0;
            r_ready <= 1'b1;
            r_run   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_n     <= w_n_next;
            r_hi    <= w_hi_next;
            r_csum  <= w_csum_next;
            r_words <= w_words_next;
            r_ptr   <= w_ptr_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_we    <= w_we_next;
            r_ready <= w_ready_next;
            r_run   <= w_run_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_next = r_state;
        w_n_next     = r_n;
        w_hi_next    = r_hi;
        w_csum_next  = r_csum;
        w_words_next = r_words;
        w_ptr_next   = r_ptr;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_we_next    = 1'b0;

        if (w_accept) begin
            case (r_state)
                // A header restarts a frame from either idle or error;
                // anything else is dropped.
                S_IDLE, S_ERR: begin
                    if (in_data == HDR) begin
                        w_state_next = S_LEN;
                        w_words_next = 8'h00;
                        w_csum_next  = 8'h00;
                        w_ptr_next   = BASE_ADDR;
                    end
                end
                S_LEN: begin
                    w_n_next     = in_data;
                    w_state_next = (in_data == 8'h00) ? S_ERR : S_HI;
                end
                S_HI: begin
                    w_hi_next    = in_data;
                    w_csum_next  = r_csum ^ in_data;
                    w_state_next = S_LO;
                end
                S_LO: begin
                    w_we_next    = 1'b1;
                    w_addr_next  = r_ptr;
                    w_wdata_next = {r_hi, in_data};
                    w_ptr_next   = r_ptr + 16'd2;   // wraps FFFE -> 0000
                    w_words_next = r_words + 8'd1;
                    w_csum_next  = r_csum ^ in_data;
                    w_state_next = ((r_words + 8'd1) == r_n) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    w_state_next = (in_data == r_csum) ? S_DONE : S_ERR;
                end
                S_DONE: begin
                    w_state_next = S_DONE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end

        // Status outputs follow the state being entered so they are
        // registered together with it.
        w_ready_next = (w_state_next != S_DONE);
        w_run_next   = (w_state_next == S_DONE);
        w_err_next   = (w_state_next == S_ERR);
    end

    assign in_ready     = r_ready;
    assign im_we        = r_we;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign cpu_run      = r_run;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
// Self-checking bench for inst_loader. Two instances share the input stream:
// one at BASE_ADDR 0000 and one at FFFC so address wrap is exercised.
// Directed scenarios use literal expectations; the random scenario uses a
// frame-level parser of the byte stream as reference.
// -----------------------------------------------------------------------------
module tb_inst_loader;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        in_ready, im_we, cpu_run, err;
    logic [15:0] im_addr, im_wdata;
    logic [7:0]  words_loaded;

    logic        w2_in_ready, w2_im_we, w2_cpu_run, w2_err;
    logic [15:0] w2_im_addr, w2_im_wdata;
    logic [7:0]  w2_words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got_q[$];
    logic [31:0] got2_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  stim_q[$];
    logic        m_err, m_run;
    logic [7:0]  m_words;

    always #5 clk = ~clk;

    inst_loader #(.BASE_ADDR(16'h0000), .HDR(HDR)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_run(cpu_run), .err(err),
        .words_loaded(words_loaded)
    );

    inst_loader #(.BASE_ADDR(16'hFFFC), .HDR(HDR)) dut_wrap (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(w2_in_ready), .im_we(w2_im_we), .im_addr(w2_im_addr),
        .im_wdata(w2_im_wdata), .cpu_run(w2_cpu_run), .err(w2_err),
        .words_loaded(w2_words_loaded)
    );

    // Record every write strobe as {addr, data}
    always @(negedge clk) begin
        if (im_we)    got_q.push_back({im_addr, im_wdata});
        if (w2_im_we) got2_q.push_back({w2_im_addr, w2_im_wdata});
    end

    function automatic logic [31:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] got2_at(input int idx);
        if (idx < got2_q.size()) return got2_q[idx];
        return 32'hxxxxxxxx;
    endfunction

    // Frame-level reference: walks stim_q as a list of frames.
    task automatic model_run(input logic [15:0] base);
        int          i;
        logic [7:0]  n, cs, hi, lo;
        logic [15:0] ptr;
        bit          trunc;
        exp_q.delete();
        m_err = 1'b0; m_run = 1'b0; m_words = 8'h00;
        i = 0;
        while (i < stim_q.size() && !m_run) begin
            if (stim_q[i] != HDR) begin i++; continue; end
            i++;
            if (i >= stim_q.size()) break;
            n = stim_q[i]; i++;
            m_words = 8'h00; m_err = 1'b0;
            if (n == 8'h00) begin m_err = 1'b1; continue; end
            ptr = base; cs = 8'h00; trunc = 1'b0;
            for (int k = 0; k < int'(n); k++) begin
                if (i + 1 >= stim_q.size()) begin trunc = 1'b1; break; end
                hi = stim_q[i]; lo = stim_q[i+1]; i += 2;
                exp_q.push_back({ptr, hi, lo});
                ptr = ptr + 16'd2;
                m_words = m_words + 8'd1;
                cs = cs ^ hi ^ lo;
            end
            if (trunc || i >= stim_q.size()) break;
            if (stim_q[i] == cs) m_run = 1'b1; else m_err = 1'b1;
            i++;
        end
    endtask

    // Present stim_q; each byte preceded by random idle cycles (gap_pct %).
    task automatic drive(input int gap_pct, input bit trail);
        for (int j = 0; j < stim_q.size(); j++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0; in_data = 8'($urandom);
                @(negedge clk);
            end
            in_data = stim_q[j]; in_valid = 1'b1;
            @(negedge clk);
        end
        if (trail) begin
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        got_q.delete(); got2_q.delete();
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_tests++; if ({in_ready, im_we, cpu_run, err} !== 4'b1000) begin n_fail++;
            $display("FAIL reset_flags got %b want 1000", {in_ready, im_we, cpu_run, err}); end
        n_tests++; if ({im_addr, im_wdata, words_loaded} !== 40'h0000_0000_00) begin n_fail++;
            $display("FAIL reset_regs got %h want 0000000000", {im_addr, im_wdata, words_loaded}); end
        n_tests++; if (w2_im_addr !== 16'hFFFC) begin n_fail++;
            $display("FAIL reset_base got %h want fffc", w2_im_addr); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got_q.delete(); got2_q.delete();
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        stim_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        drive(0, 1'b1);
        n_tests++; if (got_q.size() !== 2) begin n_fail++;
            $display("FAIL basic_nwrites got %0d want 2", got_q.size()); end
        n_tests++; if (got_at(0) !== 32'h0000_1234) begin n_fail++;
            $display("FAIL basic_w0 got %h want 00001234", got_at(0)); end
        n_tests++; if (got_at(1) !== 32'h0002_ABCD) begin n_fail++;
            $display("FAIL basic_w1 got %h want 0002abcd", got_at(1)); end
        n_tests++; if ({words_loaded, cpu_run, in_ready, err} !== 11'b00000010_100) begin n_fail++;
            $display("FAIL basic_final got wl=%0d run=%b rdy=%b err=%b want 2 1 0 0",
                     words_loaded, cpu_run, in_ready, err); end
        $display("[TB] test_basic writes=%0d run=%b", got_q.size(), cpu_run);
    endtask

    task automatic test_discard();
        do_reset();
        stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h01};
        drive(0, 1'b1);
        n_tests++; if (got_q.size() !== 1) begin n_fail++;
            $display("FAIL discard_nwrites got %0d want 1", got_q.size()); end
        n_tests++; if (got_at(0) !== 32'h0000_0001) begin n_fail++;
            $display("FAIL discard_w0 got %h want 00000001", got_at(0)); end
        n_tests++; if (cpu_run !== 1'b1) begin n_fail++;
            $display("FAIL discard_run got %b want 1", cpu_run); end
        $display("[TB] test_discard writes=%0d run=%b", got_q.size(), cpu_run);
    endtask

    task automatic test_bad_csum();
        do_reset();
        stim_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00};
        drive(0, 1'b1);
        n_tests++; if ({err, cpu_run, in_ready} !== 3'b101) begin n_fail++;
            $display("FAIL badcs_flags got err=%b run=%b rdy=%b want 1 0 1", err, cpu_run, in_ready); end
        n_tests++; if (got_q.size() !== 1 || got_at(0) !== 32'h0000_1234) begin n_fail++;
            $display("FAIL badcs_write got n=%0d %h want 1 00001234", got_q.size(), got_at(0)); end
        got_q.delete();
        stim_q = '{8'hA5, 8'h01, 8'h56, 8'h78, 8'h2E};
        drive(0, 1'b1);
        n_tests++; if ({err, cpu_run} !== 2'b01) begin n_fail++;
            $display("FAIL recover_flags got err=%b run=%b want 0 1", err, cpu_run); end
        n_tests++; if (got_q.size() !== 1 || got_at(0) !== 32'h0000_5678) begin n_fail++;
            $display("FAIL recover_write got n=%0d %h want 1 00005678", got_q.size(), got_at(0)); end
        $display("[TB] test_bad_csum err=%b run=%b", err, cpu_run);
    endtask

    task automatic test_zero_len();
        do_reset();
        stim_q = '{8'hA5, 8'h00};
        drive(0, 1'b1);
        n_tests++; if ({err, cpu_run, in_ready} !== 3'b101) begin n_fail++;
            $display("FAIL zerolen_flags got err=%b run=%b rdy=%b want 1 0 1", err, cpu_run, in_ready); end
        n_tests++; if (got_q.size() !== 0) begin n_fail++;
            $display("FAIL zerolen_nwrites got %0d want 0", got_q.size()); end
        $display("[TB] test_zero_len err=%b writes=%0d", err, got_q.size());
    endtask

    task automatic test_reset_midframe();
        do_reset();
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22};
        drive(0, 1'b0);
        // Last byte was just accepted: the write strobe is live right now.
        n_tests++; if ({im_we, im_wdata} !== 17'h1_1122) begin n_fail++;
            $display("FAIL midwrite_pre got we=%b %h want 1 1122", im_we, im_wdata); end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++; if ({im_we, im_addr, im_wdata, words_loaded} !== 41'h0) begin n_fail++;
            $display("FAIL midwrite_reset got we=%b %h %h wl=%0d want 0 0000 0000 0",
                     im_we, im_addr, im_wdata, words_loaded); end
        n_tests++; if ({in_ready, cpu_run, err} !== 3'b100) begin n_fail++;
            $display("FAIL midwrite_flags got %b want 100", {in_ready, cpu_run, err}); end
        @(negedge clk);
        reset = 1'b0;
        got_q.delete(); got2_q.delete();
        stim_q = '{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'h11};
        drive(0, 1'b1);
        n_tests++; if (got_q.size() !== 1 || got_at(0) !== 32'h0000_AABB) begin n_fail++;
            $display("FAIL midframe_write got n=%0d %h want 1 0000aabb", got_q.size(), got_at(0)); end
        n_tests++; if ({words_loaded, cpu_run} !== 9'b00000001_1) begin n_fail++;
            $display("FAIL midframe_final got wl=%0d run=%b want 1 1", words_loaded, cpu_run); end
        $display("[TB] test_reset_midframe writes=%0d run=%b", got_q.size(), cpu_run);
    endtask

    task automatic test_valid_gaps();
        logic [7:0] bytes_q[$];
        do_reset();
        bytes_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        foreach (bytes_q[j]) begin
            in_data = bytes_q[j]; in_valid = 1'b1;
            @(negedge clk);
            repeat (2) begin
                in_valid = 1'b0; in_data = 8'($urandom);
                @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        n_tests++; if (got_q.size() !== 2 || got_at(0) !== 32'h0000_1234 || got_at(1) !== 32'h0002_ABCD) begin
            n_fail++;
            $display("FAIL gaps_writes got n=%0d %h %h want 2 00001234 0002abcd",
                     got_q.size(), got_at(0), got_at(1)); end
        n_tests++; if ({words_loaded, cpu_run, in_ready, err} !== 11'b00000010_100) begin n_fail++;
            $display("FAIL gaps_final got wl=%0d run=%b rdy=%b err=%b want 2 1 0 0",
                     words_loaded, cpu_run, in_ready, err); end
        $display("[TB] test_valid_gaps writes=%0d run=%b", got_q.size(), cpu_run);
    endtask

    task automatic test_wrap();
        do_reset();
        stim_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        drive(0, 1'b1);
        n_tests++; if (got2_q.size() !== 3) begin n_fail++;
            $display("FAIL wrap_nwrites got %0d want 3", got2_q.size()); end
        n_tests++; if (got2_at(1) !== 32'hFFFE_0304) begin n_fail++;
            $display("FAIL wrap_w1 got %h want fffe0304", got2_at(1)); end
        n_tests++; if (got2_at(2) !== 32'h0000_0506) begin n_fail++;
            $display("FAIL wrap_w2 got %h want 00000506", got2_at(2)); end
        n_tests++; if (w2_cpu_run !== 1'b1) begin n_fail++;
            $display("FAIL wrap_run got %b want 1", w2_cpu_run); end
        $display("[TB] test_wrap writes=%0d run=%b", got2_q.size(), w2_cpu_run);
    endtask

    task automatic test_random();
        logic [7:0] n, cs, b;
        for (int it = 0; it < 30; it++) begin
            do_reset();
            stim_q.delete();
            repeat ($urandom_range(0, 3)) stim_q.push_back(8'($urandom));
            repeat ($urandom_range(1, 3)) begin
                n = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 6));
                stim_q.push_back(HDR);
                stim_q.push_back(n);
                cs = 8'h00;
                for (int k = 0; k < 2 * int'(n); k++) begin
                    b = 8'($urandom);
                    stim_q.push_back(b);
                    cs = cs ^ b;
                end
                if (n != 8'h00) begin
                    if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
                    stim_q.push_back(cs);
                end
            end
            drive(25, 1'b1);

            model_run(16'h0000);
            n_tests++; if (got_q.size() !== exp_q.size()) begin n_fail++;
                $display("FAIL rand%0d_nwrites got %0d want %0d", it, got_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_tests++; if (got_at(k) !== exp_q[k]) begin n_fail++;
                    $display("FAIL rand%0d_w%0d got %h want %h", it, k, got_at(k), exp_q[k]); end
            end
            n_tests++; if ({err, cpu_run, in_ready, words_loaded} !== {m_err, m_run, ~m_run, m_words}) begin
                n_fail++;
                $display("FAIL rand%0d_final got err=%b run=%b rdy=%b wl=%0d want %b %b %b %0d",
                         it, err, cpu_run, in_ready, words_loaded, m_err, m_run, ~m_run, m_words); end

            model_run(16'hFFFC);
            n_tests++; if (got2_q.size() !== exp_q.size()) begin n_fail++;
                $display("FAIL rand%0d_wrap_nwrites got %0d want %0d", it, got2_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_tests++; if (got2_at(k) !== exp_q[k]) begin n_fail++;
                    $display("FAIL rand%0d_wrap_w%0d got %h want %h", it, k, got2_at(k), exp_q[k]); end
            end
            $display("[TB] test_random iter %0d bytes=%0d writes=%0d run=%b err=%b",
                     it, stim_q.size(), got_q.size(), cpu_run, err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_discard();
        test_bad_csum();
        test_zero_len();
        test_reset_midframe();
        test_valid_gaps();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
